// File: rtl/except_ctrl_pkg.sv
// Shared constants for the exception controller: excepttype codes, CP0 addresses and field
// positions, MEM flag bit positions and FSM state type.
package except_ctrl_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_INV  = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int unsigned STATUS_IE   = 0;
  localparam int unsigned STATUS_EXL  = 1;
  localparam int unsigned CAUSE_IP_LO = 8;
  localparam int unsigned CAUSE_IP_HI = 15;

  localparam int unsigned FLAG_SYS  = 8;
  localparam int unsigned FLAG_INV  = 9;
  localparam int unsigned FLAG_TRAP = 10;
  localparam int unsigned FLAG_OV   = 11;
  localparam int unsigned FLAG_ERET = 12;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

endpackage

// File: rtl/except_ctrl_if.sv
// MEM-stage, CP0 read-back, WB-forwarding and cp0_reg/pipeline-control signals of except_ctrl.
interface except_ctrl_if;
  logic        inst_valid_i;
  logic [31:0] except_flags_i;
  logic [31:0] inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o;
  logic [31:0] except_addr_o;
  logic        except_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  modport slave (
    input  inst_valid_i, except_flags_i, inst_addr_i, is_in_delayslot_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, except_addr_o, except_delayslot_o, flush_o, new_pc_o, busy_o
  );

  modport master (
    output inst_valid_i, except_flags_i, inst_addr_i, is_in_delayslot_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, except_addr_o, except_delayslot_o, flush_o, new_pc_o, busy_o
  );
endinterface

// File: rtl/except_prio_enc.sv
// Forwards same-cycle WB mtc0 writes over CP0 read-backs and picks the highest-priority event.
module except_prio_enc
  import except_ctrl_pkg::*;
(
  input  logic        inst_valid_i,
  input  logic [31:0] except_flags_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_data_i,
  input  logic        exl_shadow_i,
  output logic [31:0] excepttype_o,
  output logic        is_eret_o,
  output logic [31:0] eff_epc_o
);

  logic [31:0] eff_status;
  logic [31:0] eff_cause;
  logic        int_req;
  logic        unused_bits;

  always_comb begin
    eff_status = status_i;
    eff_cause  = cause_i;
    eff_epc_o  = epc_i;
    if (wb_we_i) begin
      if (wb_waddr_i == CP0_STATUS) eff_status = wb_data_i;
      // Only software-writable Cause bits are forwarded; hardware IP[15:10] stays live.
      if (wb_waddr_i == CP0_CAUSE) begin
        eff_cause[9:8]   = wb_data_i[9:8];
        eff_cause[23:22] = wb_data_i[23:22];
      end
      if (wb_waddr_i == CP0_EPC) eff_epc_o = wb_data_i;
    end
  end

  assign int_req = inst_valid_i & eff_status[STATUS_IE] & ~eff_status[STATUS_EXL] & ~exl_shadow_i &
                   (|(eff_cause[CAUSE_IP_HI:CAUSE_IP_LO] & eff_status[CAUSE_IP_HI:CAUSE_IP_LO]));

  always_comb begin
    excepttype_o = EXC_NONE;
    if (int_req) begin
      excepttype_o = EXC_INT;
    end else if (inst_valid_i) begin
      if (except_flags_i[FLAG_SYS])       excepttype_o = EXC_SYS;
      else if (except_flags_i[FLAG_INV])  excepttype_o = EXC_INV;
      else if (except_flags_i[FLAG_TRAP]) excepttype_o = EXC_TRAP;
      else if (except_flags_i[FLAG_OV])   excepttype_o = EXC_OV;
      else if (except_flags_i[FLAG_ERET]) excepttype_o = EXC_ERET;
    end
  end

  assign is_eret_o = (excepttype_o == EXC_ERET);

  assign unused_bits = ^{except_flags_i[31:13], except_flags_i[7:0], eff_status[31:16],
                         eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

endmodule

// File: rtl/except_ctrl.sv
// Exception initiator: accepts one prioritised event in IDLE, issues it to cp0_reg for one cycle,
// then holds flush and the redirect target for FLUSH_CYCLES cycles.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  except_ctrl_if.slave bus
);

  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic        ds_q, ds_d;
  logic        exl_q, exl_d;

  logic [31:0] code;
  logic        is_eret;
  logic [31:0] eff_epc;

  except_prio_enc u_prio_enc (
    .inst_valid_i   (bus.inst_valid_i),
    .except_flags_i (bus.except_flags_i),
    .status_i       (bus.cp0_status_i),
    .cause_i        (bus.cp0_cause_i),
    .epc_i          (bus.cp0_epc_i),
    .wb_we_i        (bus.wb_cp0_we_i),
    .wb_waddr_i     (bus.wb_cp0_waddr_i),
    .wb_data_i      (bus.wb_cp0_data_i),
    .exl_shadow_i   (exl_q),
    .excepttype_o   (code),
    .is_eret_o      (is_eret),
    .eff_epc_o      (eff_epc)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    new_pc_d = new_pc_q;
    type_d   = EXC_NONE;
    addr_d   = '0;
    ds_d     = 1'b0;
    exl_d    = exl_q;
    // Once CP0 shows EXL itself the shadow is no longer needed.
    if (bus.cp0_status_i[STATUS_EXL]) exl_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (code != EXC_NONE) begin
          state_d  = StFlush;
          cnt_d    = FlushInit;
          flush_d  = 1'b1;
          new_pc_d = is_eret ? eff_epc : EXC_VECTOR;
          type_d   = code;
          addr_d   = bus.inst_addr_i;
          ds_d     = bus.is_in_delayslot_i;
          exl_d    = ~is_eret;
        end
      end
      StFlush: begin
        if (cnt_q == 4'd0) begin
          state_d  = StIdle;
          flush_d  = 1'b0;
          new_pc_d = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
      type_q   <= EXC_NONE;
      addr_q   <= '0;
      ds_q     <= 1'b0;
      exl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      ds_q     <= ds_d;
      exl_q    <= exl_d;
    end
  end

  assign bus.excepttype_o       = type_q;
  assign bus.except_addr_o      = addr_q;
  assign bus.except_delayslot_o = ds_q;
  assign bus.flush_o            = flush_q;
  assign bus.new_pc_o           = new_pc_q;
  assign bus.busy_o             = (state_q == StFlush);

endmodule

// File: tb/tb_except_ctrl.sv
// Scoreboard bench for except_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model of the exception rules.
module tb_except_ctrl;

  localparam int unsigned FLUSH = 2;
  localparam logic [31:0] VEC   = 32'h0000_0040;

  typedef struct {
    int          due;
    logic [31:0] etype;
    logic [31:0] addr;
    logic        ds;
    logic [31:0] npc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  except_ctrl_if bus ();

  except_ctrl #(
    .EXC_VECTOR   (VEC),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb_q[$];

  // Stimulus values applied by step()
  logic        b_valid, b_ds, b_we;
  logic [31:0] b_flags, b_pc, b_status, b_cause, b_epc, b_wdata;
  logic [4:0]  b_waddr;

  // Reference model state
  int   m_busy = 0;
  logic m_exl  = 1'b0;

  int unsigned sync_bit  [5] = '{8, 9, 10, 11, 12};
  logic [31:0] sync_code [5] = '{32'h8, 32'ha, 32'hd, 32'hc, 32'he};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic [31:0] st, ca, ep, code;
    logic        intr;
    exp_t        e;
    st = b_status;
    ca = b_cause;
    ep = b_epc;
    if (b_we && b_waddr == 5'd12) st = b_wdata;
    if (b_we && b_waddr == 5'd13) begin
      ca[9:8]   = b_wdata[9:8];
      ca[23:22] = b_wdata[23:22];
    end
    if (b_we && b_waddr == 5'd14) ep = b_wdata;
    intr = b_valid && st[0] && !st[1] && !m_exl && ((ca[15:8] & st[15:8]) != 8'h0);
    if (b_status[1]) m_exl = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
      return;
    end
    code = 32'h0;
    if (intr) code = 32'h1;
    else if (b_valid) begin
      for (int k = 4; k >= 0; k--) if (b_flags[sync_bit[k]]) code = sync_code[k];
    end
    if (code != 32'h0) begin
      e.due   = cyc + 1;
      e.etype = code;
      e.addr  = b_pc;
      e.ds    = b_ds;
      e.npc   = (code == 32'he) ? ep : VEC;
      sb_q.push_back(e);
      m_busy = FLUSH;
      m_exl  = (code != 32'he);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.inst_valid_i      = b_valid;
    bus.except_flags_i    = b_flags;
    bus.inst_addr_i       = b_pc;
    bus.is_in_delayslot_i = b_ds;
    bus.cp0_status_i      = b_status;
    bus.cp0_cause_i       = b_cause;
    bus.cp0_epc_i         = b_epc;
    bus.wb_cp0_we_i       = b_we;
    bus.wb_cp0_waddr_i    = b_waddr;
    bus.wb_cp0_data_i     = b_wdata;
    model_step();
  endtask

  task automatic set_quiet();
    b_valid = 1'b0; b_flags = '0; b_pc = '0; b_ds = 1'b0; b_status = '0; b_cause = '0;
    b_epc = '0; b_we = 1'b0; b_waddr = '0; b_wdata = '0;
  endtask

  task automatic idle(input int n);
    b_valid = 1'b0; b_flags = '0; b_we = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor
  exp_t        mon_e;
  int          run = 0;
  logic [31:0] npc_hold = '0;

  always @(negedge clk) begin
    if (!rst) begin
      run = 0;
    end else begin
      if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
        mon_e = sb_q.pop_front();
        chk("excepttype", bus.excepttype_o, mon_e.etype);
        chk("except_addr", bus.except_addr_o, mon_e.addr);
        chk("except_delayslot", 32'(bus.except_delayslot_o), 32'(mon_e.ds));
        chk("new_pc", bus.new_pc_o, mon_e.npc);
        chk("flush_on_issue", 32'(bus.flush_o), 32'd1);
        npc_hold = mon_e.npc;
      end else begin
        chk("spurious_excepttype", bus.excepttype_o, 32'h0);
      end
      if (bus.flush_o) begin
        run++;
        chk("new_pc_stable", bus.new_pc_o, npc_hold);
      end else begin
        if (run != 0) chk("flush_len", 32'(run), 32'(FLUSH));
        chk("new_pc_idle", bus.new_pc_o, 32'h0);
        run = 0;
      end
    end
  end

  initial begin
    set_quiet();
    step();
    step();
    chk("rst_excepttype", bus.excepttype_o, 32'h0);
    chk("rst_addr", bus.except_addr_o, 32'h0);
    chk("rst_ds", 32'(bus.except_delayslot_o), 32'h0);
    chk("rst_flush", 32'(bus.flush_o), 32'h0);
    chk("rst_new_pc", bus.new_pc_o, 32'h0);
    chk("rst_busy", 32'(bus.busy_o), 32'h0);
    rst = 1'b1;
    idle(2);

    // Syscall at 0x100
    b_valid = 1'b1; b_flags = 32'h100; b_pc = 32'h100; b_ds = 1'b0;
    step();
    idle(4);
    b_status = 32'h2; step();
    b_status = 32'h0; idle(1);

    // Interrupt pending, bubbles first, then valid delay-slot instruction
    b_status = 32'h401; b_cause = 32'h400; b_pc = 32'h204; b_ds = 1'b1;
    idle(3);
    b_valid = 1'b1; step();
    b_valid = 1'b0; b_status = 32'h2; b_cause = 32'h0; b_ds = 1'b0;
    idle(4);

    // eret with WB forwarding EPC
    b_status = 32'h0; b_valid = 1'b1; b_flags = 32'h1000; b_epc = 32'h80;
    b_we = 1'b1; b_waddr = 5'd14; b_wdata = 32'h200;
    step();
    idle(4);

    // Interrupt + overflow together; interrupt held while EXL lags
    b_status = 32'h401; b_cause = 32'h400; b_valid = 1'b1; b_flags = 32'h800; b_pc = 32'h300;
    step();
    b_flags = 32'h0;
    for (int i = 0; i < 4; i++) step();
    b_status = 32'h403; step();
    b_valid = 1'b0; b_status = 32'h0;
    idle(3);

    // WB clears Status in the same cycle as a pending IP
    b_status = 32'h401; b_cause = 32'h400; b_valid = 1'b1; b_pc = 32'h400;
    b_we = 1'b1; b_waddr = 5'd12; b_wdata = 32'h0;
    step();
    b_we = 1'b0; b_status = 32'h0;
    idle(3);

    // Reset mid-flush
    b_valid = 1'b1; b_flags = 32'h100; b_pc = 32'h500;
    step();
    idle(1);
    @(posedge clk);
    #3;
    chk("flush_before_reset", 32'(bus.flush_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_flush", 32'(bus.flush_o), 32'h0);
    chk("async_rst_new_pc", bus.new_pc_o, 32'h0);
    chk("async_rst_excepttype", bus.excepttype_o, 32'h0);
    chk("async_rst_busy", 32'(bus.busy_o), 32'h0);
    sb_q.delete();
    m_busy = 0;
    m_exl  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("busy_after_reset", 32'(bus.busy_o), 32'h0);
    b_status = 32'h401; b_cause = 32'h400; b_valid = 1'b1; b_pc = 32'h600;
    step();
    b_status = 32'h0;
    idle(4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      b_valid  = ($urandom_range(0, 9) != 0);
      b_flags  = '0;
      r = $urandom_range(0, 9);
      if (r < 5) b_flags[8 + r] = 1'b1;
      if ($urandom_range(0, 7) == 0) b_flags[8 + $urandom_range(0, 4)] = 1'b1;
      b_flags[7:0] = 8'($urandom);
      b_pc     = {$urandom} & 32'hffff_fffc;
      b_ds     = 1'($urandom);
      b_status = '0;
      b_status[0] = ($urandom_range(0, 3) != 0);
      b_status[1] = ($urandom_range(0, 3) == 0);
      b_status[15:8] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h0;
      b_cause  = $urandom;
      if ($urandom_range(0, 1) != 0) b_cause[15:8] = 8'h0;
      b_epc    = $urandom;
      b_we     = ($urandom_range(0, 2) == 0);
      b_waddr  = 5'(12 + $urandom_range(0, 3));
      b_wdata  = $urandom;
      step();
    end
    idle(5);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
